pcm_mem_arbiter: RTL and testbench

- Memory-side responder for the four SLC-3 CPU cores' SRAM-style memory ports.
- Accepts their active-low CE/OE/WE/UB/LB requests and arbitrates them round-robin onto the single 2K×16 PCM memory port (Avalon-MM, read latency 1) that is shared with the Nios system.
- Returns read data and a one-cycle ready pulse to the winning CPU.

---
 rtl/pcm_mem_pkg.sv | 30 +++
 rtl/pcm_mem_arbiter_if.sv | 48 ++++
 rtl/pcm_rr_arbiter.sv | 43 ++++
 rtl/pcm_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_pcm_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcm_mem_pkg.sv
// Shared types and constants for the SLC-3 CPU to PCM memory arbiter.
// The state enum, default geometry and address-range helper live here.
package pcm_mem_pkg;

  localparam int PCM_NPORTS     = 4;
  localparam int PCM_ADDR_W     = 11;
  localparam int PCM_DATA_W     = 16;
  localparam int PCM_CPU_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } pcm_arb_state_t;

  // Flags captured with a grant and carried through ISSUE/RESP
  typedef struct packed {
    logic wr;
    logic oob;
  } pcm_req_flags_t;

  // CPU addresses above the PCM window must never reach the memory
  function automatic logic addr_out_of_range(
    input logic [PCM_CPU_ADDR_W-1:0] addr,
    input int unsigned               addr_w
  );
    return (addr >> addr_w) != '0;
  endfunction

endpackage

// File: rtl/pcm_mem_arbiter_if.sv
// Bundle of the four CPU SRAM-style ports plus the shared Avalon-MM PCM port.
// slave is the arbiter's view; master is the CPU/memory environment's view.
interface pcm_mem_arbiter_if
  import pcm_mem_pkg::*;
#(
  parameter int NPORTS = PCM_NPORTS,
  parameter int ADDR_W = PCM_ADDR_W,
  parameter int DATA_W = PCM_DATA_W
) ();

  logic [NPORTS-1:0]                      cpu_ce_n;
  logic [NPORTS-1:0]                      cpu_oe_n;
  logic [NPORTS-1:0]                      cpu_we_n;
  logic [NPORTS-1:0]                      cpu_ub_n;
  logic [NPORTS-1:0]                      cpu_lb_n;
  logic [NPORTS-1:0][PCM_CPU_ADDR_W-1:0]  cpu_addr;
  logic [NPORTS-1:0][DATA_W-1:0]          cpu_wdata;
  logic [NPORTS-1:0][DATA_W-1:0]          cpu_rdata;
  logic [NPORTS-1:0]                      cpu_ready;
  logic                                   oob_err;

  logic [ADDR_W-1:0]                      mem_address;
  logic                                   mem_chipselect;
  logic                                   mem_clken;
  logic                                   mem_write;
  logic [DATA_W-1:0]                      mem_writedata;
  logic [1:0]                             mem_byteenable;
  logic [DATA_W-1:0]                      mem_readdata;

  modport slave (
    input  cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, oob_err,
    output mem_address, mem_chipselect, mem_clken, mem_write,
    output mem_writedata, mem_byteenable,
    input  mem_readdata
  );

  modport master (
    output cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, oob_err,
    input  mem_address, mem_chipselect, mem_clken, mem_write,
    input  mem_writedata, mem_byteenable,
    output mem_readdata
  );

endinterface

// File: rtl/pcm_rr_arbiter.sv
// Round-robin grant selection: rr_ptr names the highest-priority port and
// advances to the port after the winner whenever a grant is taken.
module pcm_rr_arbiter
  import pcm_mem_pkg::*;
#(
  parameter int NPORTS = PCM_NPORTS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NPORTS-1:0]         eligible,
  input  logic                      take,
  output logic                      gnt_vld,
  output logic [$clog2(NPORTS)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NPORTS);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pos;

  // Scan from the farthest position down so the closest eligible port wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(rr_ptr) + k) % NPORTS);
      if (eligible[pos]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= IDX_W'((int'(gnt_idx) + 1) % NPORTS);
    end
  end

endmodule

// File: rtl/pcm_mem_arbiter.sv
// Memory-side responder for four SLC-3 CPU ports sharing one 2Kx16 PCM
// Avalon-MM port (read latency 1): grant in IDLE, drive in ISSUE, answer after RESP.
module pcm_mem_arbiter
  import pcm_mem_pkg::*;
#(
  parameter int NPORTS = PCM_NPORTS,
  parameter int ADDR_W = PCM_ADDR_W,
  parameter int DATA_W = PCM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  pcm_mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NPORTS);

  pcm_arb_state_t   state;
  pcm_arb_state_t   state_nxt;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] served;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] gnt_oh;
  logic              gnt_vld;
  logic [IDX_W-1:0]  gnt_idx;
  logic              take;
  pcm_req_flags_t    gnt_flags;

  logic [IDX_W-1:0]  cur_idx;
  pcm_req_flags_t    cur_flags;

  // A port requests with CE low and either strobe low; WE low wins over OE
  assign req      = ~bus.cpu_ce_n & (~bus.cpu_we_n | ~bus.cpu_oe_n);
  assign eligible = req & ~served;
  assign take     = (state == IDLE) && gnt_vld;
  assign gnt_oh   = take ? (NPORTS'(1) << gnt_idx) : '0;

  assign gnt_flags.wr  = ~bus.cpu_we_n[gnt_idx];
  assign gnt_flags.oob = addr_out_of_range(bus.cpu_addr[gnt_idx], ADDR_W);

  assign bus.mem_clken = reset_n;

  pcm_rr_arbiter #(
    .NPORTS (NPORTS)
  ) u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .eligible (eligible),
    .take     (take),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // served keeps a CPU that holds CE low after ready from a second service
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      served <= '0;
    end else begin
      served <= gnt_oh | (served & ~bus.cpu_ce_n);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant edge: latch the request straight into the memory-side registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_idx            <= '0;
      cur_flags          <= '0;
      bus.mem_address    <= '0;
      bus.mem_writedata  <= '0;
      bus.mem_byteenable <= '0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
    end else if (take) begin
      cur_idx            <= gnt_idx;
      cur_flags          <= gnt_flags;
      bus.mem_address    <= bus.cpu_addr[gnt_idx][ADDR_W-1:0];
      bus.mem_writedata  <= bus.cpu_wdata[gnt_idx];
      bus.mem_byteenable <= ~{bus.cpu_ub_n[gnt_idx], bus.cpu_lb_n[gnt_idx]};
      bus.mem_chipselect <= ~gnt_flags.oob;
      bus.mem_write      <= gnt_flags.wr & ~gnt_flags.oob;
    end else begin
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
    end
  end

  // RESP exit: readdata is valid now; out-of-range reads return zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= '0;
      bus.oob_err   <= 1'b0;
    end else begin
      bus.cpu_ready <= '0;
      bus.oob_err   <= 1'b0;
      if (state == RESP) begin
        bus.cpu_ready[cur_idx] <= 1'b1;
        bus.oob_err            <= cur_flags.oob;
        if (!cur_flags.wr) begin
          bus.cpu_rdata[cur_idx] <= cur_flags.oob ? '0 : bus.mem_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// Bench for pcm_mem_arbiter: PCM memory model on the Avalon side, a reference
// model predicting each completion, and a monitor that checks every ready pulse.
`timescale 1ns/1ps
module tb_pcm_mem_arbiter;
  import pcm_mem_pkg::*;

  localparam int NP = 4;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pcm_mem_arbiter_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  pcm_mem_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic [15:0] data;
    bit          oob;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [0:2047];
  logic [15:0] last_rd [NP];
  int          rr_model;
  logic [15:0] pcm [0:2047];

  // Avalon PCM memory, read latency 1, byte-lane writes
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        if (bus.mem_byteenable[0]) pcm[bus.mem_address][7:0]  <= bus.mem_writedata[7:0];
        if (bus.mem_byteenable[1]) pcm[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
      end else begin
        bus.mem_readdata <= pcm[bus.mem_address];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural prediction of one completed access, in service order
  function automatic void model_issue(int p, bit wr, logic [15:0] a, logic [15:0] d,
                                      bit ub_n, bit lb_n);
    exp_t e;
    bit   oob;
    oob    = (a >= 16'd2048);
    e.port = p;
    e.oob  = oob;
    if (wr) begin
      if (!oob) begin
        if (!lb_n) ref_mem[a[10:0]][7:0]  = d[7:0];
        if (!ub_n) ref_mem[a[10:0]][15:8] = d[15:8];
      end
      e.data = last_rd[p];
    end else begin
      e.data     = oob ? 16'h0000 : ref_mem[a[10:0]];
      last_rd[p] = e.data;
    end
    sb.push_back(e);
    rr_model = (p + 1) % NP;
  endfunction

  function automatic void model_reset();
    rr_model = 0;
    for (int i = 0; i < NP; i++) last_rd[i] = 16'h0000;
  endfunction

  task automatic drive_port(int p, bit wr, logic [15:0] a, logic [15:0] d,
                            bit ub_n, bit lb_n, bit both_low);
    bus.cpu_ce_n[p]  = 1'b0;
    bus.cpu_we_n[p]  = !wr;
    bus.cpu_oe_n[p]  = wr ? !both_low : 1'b0;
    bus.cpu_ub_n[p]  = ub_n;
    bus.cpu_lb_n[p]  = lb_n;
    bus.cpu_addr[p]  = a;
    bus.cpu_wdata[p] = d;
  endtask

  task automatic release_port(int p);
    bus.cpu_ce_n[p] = 1'b1;
    bus.cpu_we_n[p] = 1'b1;
    bus.cpu_oe_n[p] = 1'b1;
  endtask

  // One access from an otherwise idle set of ports; cycle 1 = ISSUE
  task automatic do_access(input int p, input bit wr, input logic [15:0] a,
                           input logic [15:0] d, input bit ub_n, input bit lb_n,
                           input bit both_low, output int lat, output int cs_cnt,
                           output int wr_cnt, output logic [1:0] be_seen,
                           output logic oob_seen);
    model_issue(p, wr, a, d, ub_n, lb_n);
    drive_port(p, wr, a, d, ub_n, lb_n, both_low);
    lat = -1; cs_cnt = 0; wr_cnt = 0; be_seen = 2'bxx; oob_seen = 1'bx;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.mem_chipselect) begin cs_cnt++; be_seen = bus.mem_byteenable; end
      if (bus.mem_write) wr_cnt++;
      if (bus.cpu_ready[p]) begin lat = n; oob_seen = bus.oob_err; break; end
    end
    release_port(p);
    @(posedge clk); #1;
  endtask

  // Simultaneous requests on every port in mask; service order follows rr_model
  task automatic multi(input logic [3:0] mask, input bit rand_ops, input string tag);
    int order[$];
    int seen[NP];
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (rr_model + k) % NP;
      if (mask[p]) order.push_back(p);
    end
    foreach (order[j]) begin
      bit wr;
      logic [15:0] a, d;
      bit ub, lb, bl;
      wr = rand_ops ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      ub = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      bl = 1'($urandom_range(0, 1));
      model_issue(order[j], wr, a, d, ub, lb);
      drive_port(order[j], wr, a, d, ub, lb, bl);
    end
    for (int i = 0; i < NP; i++) seen[i] = -1;
    @(posedge clk);
    for (int n = 1; n <= 3 * NP + 3; n++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++)
        if (bus.cpu_ready[i] && seen[i] < 0) seen[i] = n;
    end
    foreach (order[j]) check($sformatf("%s_ready_cycle_p%0d", tag, order[j]),
                             64'(seen[order[j]]), 64'(3 * (j + 1)));
    for (int i = 0; i < NP; i++) if (mask[i]) release_port(i);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every ready pulse must match the next prediction
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.cpu_ready == '0) begin
          if (bus.oob_err) begin
            checks++; errors++;
            $display("FAIL oob_without_ready: got oob_err=1 required 0");
          end
        end else begin
          check("ready_onehot", 64'($countones(bus.cpu_ready)), 64'd1);
          for (int i = 0; i < NP; i++) begin
            if (bus.cpu_ready[i]) begin
              if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: port %0d pulsed, required no ready", i);
              end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_port", 64'(i), 64'(e.port));
                check("sb_oob", 64'(bus.oob_err), 64'(e.oob));
                check("sb_rdata", 64'(bus.cpu_rdata[i]), 64'(e.data));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, cs_cnt, wr_cnt, wcnt, rcnt;
    logic [1:0] be;
    logic oobs;

    for (int i = 0; i < 2048; i++) begin pcm[i] = '0; ref_mem[i] = '0; end
    bus.mem_readdata = '0;
    for (int i = 0; i < NP; i++) begin
      release_port(i);
      bus.cpu_ub_n[i] = 1'b1; bus.cpu_lb_n[i] = 1'b1;
      bus.cpu_addr[i] = '0;   bus.cpu_wdata[i] = '0;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.cpu_ready), 64'd0);
    check("rst_oob", 64'(bus.oob_err), 64'd0);
    check("rst_cs", 64'(bus.mem_chipselect), 64'd0);
    check("rst_write", 64'(bus.mem_write), 64'd0);
    check("rst_clken", 64'(bus.mem_clken), 64'd0);
    check("rst_addr", 64'(bus.mem_address), 64'd0);
    check("rst_wdata", 64'(bus.mem_writedata), 64'd0);
    check("rst_be", 64'(bus.mem_byteenable), 64'd0);
    check("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("clken_run", 64'(bus.mem_clken), 64'd1);

    // Single write then read-back on port 1
    do_access(1, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_cs", 64'(cs_cnt), 64'd1);
    check("wr_write", 64'(wr_cnt), 64'd1);
    check("wr_be", 64'(be), 64'd3);
    do_access(1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_write", 64'(wr_cnt), 64'd0);
    check("rd_beef", 64'(bus.cpu_rdata[1]), 64'hBEEF);

    // Byte lane merge on port 0; both strobes low counts as a write
    do_access(0, 1'b1, 16'h0010, 16'hFFFF, 1'b0, 1'b0, 1'b1, lat, cs_cnt, wr_cnt, be, oobs);
    do_access(0, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("lane_be", 64'(be), 64'd1);
    do_access(0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("lane_readback", 64'(bus.cpu_rdata[0]), 64'hFF34);

    // Full contention straight from reset: order 0,1,2,3
    #2 reset_n = 1'b0;
    model_reset();
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    multi(4'hF, 1'b0, "contend");
    do_access(2, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("contend_p2_again", 64'(lat), 64'd3);

    // Port 3 holds CE/WE low for 20 cycles: serviced exactly once
    model_issue(3, 1'b1, 16'h0007, 16'hA5A5, 1'b0, 1'b0);
    drive_port(3, 1'b1, 16'h0007, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    wcnt = 0; rcnt = 0;
    @(posedge clk);
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_write) wcnt++;
      if (bus.cpu_ready[3]) rcnt++;
    end
    check("held_write_pulses", 64'(wcnt), 64'd1);
    check("held_ready_pulses", 64'(rcnt), 64'd1);
    release_port(3);
    @(posedge clk); #1;

    // Out-of-range read and dropped out-of-range write
    do_access(2, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("oob_latency", 64'(lat), 64'd3);
    check("oob_cs", 64'(cs_cnt), 64'd0);
    check("oob_flag", 64'(oobs), 64'd1);
    check("oob_rdata", 64'(bus.cpu_rdata[2]), 64'd0);
    do_access(1, 1'b1, 16'h0805, 16'h5555, 1'b0, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("oob_wr_cs", 64'(cs_cnt), 64'd0);
    do_access(1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, lat, cs_cnt, wr_cnt, be, oobs);
    check("oob_wr_dropped", 64'(bus.cpu_rdata[1]), 64'hBEEF);

    // Reset during ISSUE of a port 0 read
    drive_port(0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_cs_before", 64'(bus.mem_chipselect), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_cs_now", 64'(bus.mem_chipselect), 64'd0);
    release_port(0);
    model_reset();
    rcnt = 0;
    repeat (3) begin @(negedge clk); if (bus.cpu_ready != '0) rcnt++; end
    check("midrst_no_ready", 64'(rcnt), 64'd0);
    check("midrst_rdata_clear", 64'(bus.cpu_rdata), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    multi(4'b0011, 1'b0, "postrst");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [3:0] m;
        m = 4'($urandom_range(1, 15));
        multi(m, 1'b1, "rand_multi");
      end else begin
        int p;
        bit wr, ub, lb, bl;
        logic [15:0] a, d;
        p  = $urandom_range(0, NP - 1);
        wr = 1'($urandom_range(0, 1));
        ub = 1'($urandom_range(0, 1));
        lb = 1'($urandom_range(0, 1));
        bl = 1'($urandom_range(0, 1));
        d  = 16'($urandom);
        if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(2048, 65535));
        else                           a = 16'($urandom_range(0, 15));
        do_access(p, wr, a, d, ub, lb, bl, lat, cs_cnt, wr_cnt, be, oobs);
        check("rand_latency", 64'(lat), 64'd3);
        check("rand_cs", 64'(cs_cnt), (a >= 16'd2048) ? 64'd0 : 64'd1);
      end
    end

    repeat (5) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
